// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: FSM state encoding and time-field limits shared by the stopwatch blocks.
package stopwatch_pkg;
    typedef enum logic [1:0] {STOP = 2'd0, RUN = 2'd1, CLEAR = 2'd2} state_t;
    localparam int MSEC_MAX = 99;
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;
endpackage

// File: rtl/stopwatch_time_gen_tick_gen.sv
// tick_gen: divides clk down to a one-cycle tick at the terminal count; holds phase when disabled.
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int W = $clog2(DIV);
    logic [W-1:0] cnt;
    assign tick = enable && cnt == W'(DIV - 1);
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/stopwatch_time_gen.sv
// stopwatch_time_gen: run/stop/clear stopwatch producing hh:mm:ss.cc with a single-edge carry cascade.
// Defining STOPWATCH_LAP_EN adds a lap freeze of the outputs driven by btn_lap.
module stopwatch_time_gen
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_run_stop,
    input  logic       btn_clear,
    input  logic       btn_lap,
    output logic [6:0] msec,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic       running,
    output logic       lap_active
);
    state_t state, next_state;
    logic tick, clr, c_ms, c_s, c_m;
    logic [6:0] msec_q, msec_d;
    logic [5:0] sec_q, sec_d, min_q, min_d;
    logic [4:0] hour_q, hour_d;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state   <= STOP;
            running <= 1'b0;
        end else begin
            state   <= next_state;
            running <= next_state == RUN;
        end

    always_comb begin
        next_state = state;
        unique case (state)
            STOP:    next_state = btn_clear ? CLEAR : btn_run_stop ? RUN : STOP;
            RUN:     next_state = btn_run_stop ? STOP : RUN;
            default: next_state = STOP;
        endcase
    end

    assign clr = state == CLEAR;

    tick_gen #(.DIV(CLK_FREQ / TICK_HZ)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (state == RUN),
        .clear  (clr),
        .tick   (tick)
    );

    // carries are all decoded from current values so the whole cascade lands on one edge
    assign c_ms = tick && msec_q == 7'(MSEC_MAX);
    assign c_s  = c_ms && sec_q == 6'(SEC_MAX);
    assign c_m  = c_s && min_q == 6'(MIN_MAX);

    always_comb begin
        msec_d = clr ? '0 : !tick ? msec_q : c_ms ? '0 : msec_q + 7'd1;
        sec_d  = clr ? '0 : !c_ms ? sec_q : c_s ? '0 : sec_q + 6'd1;
        min_d  = clr ? '0 : !c_s ? min_q : c_m ? '0 : min_q + 6'd1;
        hour_d = clr ? '0 : !c_m ? hour_q : hour_q == 5'(HOUR_MAX) ? '0 : hour_q + 5'd1;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            msec_q <= '0;
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= '0;
        end else begin
            msec_q <= msec_d;
            sec_q  <= sec_d;
            min_q  <= min_d;
            hour_q <= hour_d;
        end

`ifdef STOPWATCH_LAP_EN
    logic       lap;
    logic [6:0] msec_s;
    logic [5:0] sec_s, min_s;
    logic [4:0] hour_s;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            lap    <= 1'b0;
            msec_s <= '0;
            sec_s  <= '0;
            min_s  <= '0;
            hour_s <= '0;
        end else if (clr || (state == RUN && btn_run_stop)) begin
            lap <= 1'b0;
        end else if (state == RUN && btn_lap) begin
            lap    <= !lap;
            msec_s <= msec_q;
            sec_s  <= sec_q;
            min_s  <= min_q;
            hour_s <= hour_q;
        end

    assign lap_active = lap;
    assign msec       = lap ? msec_s : msec_q;
    assign sec        = lap ? sec_s : sec_q;
    assign min        = lap ? min_s : min_q;
    assign hour       = lap ? hour_s : hour_q;
`else
    logic unused_lap;
    assign unused_lap = btn_lap;
    assign lap_active = 1'b0;
    assign msec       = msec_q;
    assign sec        = sec_q;
    assign min        = min_q;
    assign hour       = hour_q;
`endif
endmodule

// File: doc/stopwatch_time_gen.md
STOPWATCH_TIME_GEN -- requirements
Module: stopwatch_time_gen

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 100, centisecond tick rate; CLK_FREQ/TICK_HZ SHALL be an integer >= 2.
REQ-003 SHALL have clk  input  1  single system clock, rising edge.
REQ-004 SHALL have reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have btn_run_stop  input  1  one-cycle pulse, already debounced and synchronous to clk; toggles run/stop.
REQ-006 SHALL have btn_clear  input  1  one-cycle pulse, synchronous to clk; clears time.
REQ-007 SHALL have btn_lap  input  1  one-cycle pulse; lap freeze toggle (see Configuration).
REQ-008 SHALL have msec  output  7  centiseconds, 0..99.
REQ-009 SHALL have sec  output  6  seconds, 0..59.
REQ-010 SHALL have min  output  6  minutes, 0..59.
REQ-011 SHALL have hour  output  5  hours, 0..23.
REQ-012 SHALL have running  output  1  high while the FSM is in RUN.
REQ-013 SHALL have lap_active  output  1  high while outputs are frozen.

Function
REQ-014 SHALL implement an FSM with states STOP, RUN, CLEAR.
REQ-015 STOP plus btn_run_stop SHALL go to RUN; RUN plus btn_run_stop SHALL go to STOP.
REQ-016 STOP plus btn_clear SHALL go to CLEAR; CLEAR SHALL return to STOP after exactly one cycle.
REQ-017 btn_clear SHALL be ignored in RUN, and all buttons SHALL be ignored in CLEAR.
REQ-018 In STOP, if btn_clear and btn_run_stop are high in the same cycle, clear SHALL win.
REQ-019 The tick divider SHALL count 0..CLK_FREQ/TICK_HZ-1 only in RUN, and SHALL emit a one-cycle tick at the terminal count while wrapping to 0.
REQ-020 The divider SHALL hold its value in STOP, preserving sub-tick phase on resume, and SHALL be zeroed in CLEAR.
REQ-021 On a tick, msec SHALL increment; at 99 it SHALL wrap to 0 and carry to sec.
REQ-022 sec SHALL wrap 59->0 with carry to min, and min SHALL wrap 59->0 with carry to hour.
REQ-023 hour SHALL wrap 23->0, so that 23:59:59.99 plus one tick gives 00:00:00.00 with no other effect.
REQ-024 All cascade updates SHALL occur on the same clock edge as the tick, visible the following cycle; there SHALL be no multi-cycle ripple.
REQ-025 CLEAR SHALL zero all four time counters on the edge entering STOP.
REQ-026 running SHALL be registered and SHALL equal (state == RUN).

Reset
REQ-027 While reset is low, state SHALL be STOP, the divider 0, all time outputs 0, running 0, and lap_active 0.
REQ-028 Reset asserted mid-RUN SHALL abort immediately; after release, the block SHALL stay in STOP until btn_run_stop.

Configuration
REQ-029 Macro STOPWATCH_LAP_EN SHALL compile the lap feature in or out.
REQ-030 With STOPWATCH_LAP_EN defined, btn_lap in RUN SHALL toggle lap_active.
REQ-031 While lap_active is high, outputs SHALL hold the snapshot taken at the press edge while internal counting continues; a second press SHALL release the outputs to live values.
REQ-032 With STOPWATCH_LAP_EN defined, entering CLEAR or reset SHALL drop lap_active; leaving RUN to STOP SHALL also drop lap_active.
REQ-033 Without STOPWATCH_LAP_EN, btn_lap SHALL be ignored, lap_active SHALL be tied 0, and outputs SHALL always be live; the port list SHALL be identical in both builds.

Structure
REQ-034 Package stopwatch_pkg SHALL hold the state encoding (STOP=2'd0, RUN=2'd1, CLEAR=2'd2) and the limits MSEC_MAX=99, SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
REQ-035 Sub-module tick_gen SHALL contain the divider, with inputs enable and clear and output tick, and SHALL be instantiated once.

Verification (CLK_FREQ=1000, TICK_HZ=100, giving 10 clocks per tick)
REQ-036 Reset release, btn_run_stop, then 100 ticks -> msec=0, sec=1, running=1.
REQ-037 Preload to 23:59:59.98 via run, then 2 ticks -> 00:00:00.00, all fields wrap in one edge.
REQ-038 Stop after 7 divider clocks, wait 50 cycles, resume -> next tick arrives after 3 more clocks.
REQ-039 In STOP, btn_clear and btn_run_stop in the same cycle -> CLEAR then STOP, all outputs 0, running=0.
REQ-040 With STOPWATCH_LAP_EN defined: lap at 00:00:01.23 with 50 more ticks -> outputs hold 1.23; second lap -> outputs show 1.73. Without the macro -> outputs stay live and lap_active=0.
REQ-041 reset pulsed low mid-RUN at 00:00:05.00 -> outputs 0 immediately (asynchronous), state STOP after release.
